// File: rtl/da_pkg.sv
// Shared types and sizing helpers for the distributed-arithmetic shift-accumulator.
package da_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACC,
      DONE
   } da_acc_state_t;

   // Result width: LUT sum width + negation guard bit + one bit per slice weight.
   function automatic int acc_width(input int data_width_a, input int data_width_b, input int k);
      return data_width_b + $clog2(k) + 1 + data_width_a;
   endfunction

   function automatic int cnt_width(input int data_width_a);
      return (data_width_a > 1) ? $clog2(data_width_a) : 1;
   endfunction

   localparam int DA_CNT_WIDTH = cnt_width(16);

endpackage

// File: rtl/da_term_weight.sv
// Combinational slice term: sign-extend the LUT sum, apply the slice sign, weight by 2^cnt.
module da_term_weight #(
   parameter int LUT_WIDTH = 20,
   parameter int ACC_WIDTH = 37,
   parameter int CNT_WIDTH = 4
) (
   input  logic signed [LUT_WIDTH:0]   lut_in,
   input  logic                        sign_in,
   input  logic [CNT_WIDTH-1:0]        cnt,
   output logic signed [ACC_WIDTH-1:0] weighted
);

   logic signed [ACC_WIDTH-1:0] ext;
   logic signed [ACC_WIDTH-1:0] term;

   // Extend before negating so the most negative LUT value cannot wrap.
   assign ext      = {{(ACC_WIDTH-LUT_WIDTH-1){lut_in[LUT_WIDTH]}}, lut_in};
   assign term     = sign_in ? ext : -ext;
   assign weighted = term <<< cnt;

endmodule

// File: rtl/da_shift_acc.sv
// Bit-serial DA shift-accumulator with valid/ready result output.
// Optional macro DA_OBC_OFFSET_EN adds offset_in, used as the accumulator start value.
module da_shift_acc
   import da_pkg::*;
#(
   parameter int DATA_WIDTH_A = 16,
   parameter int DATA_WIDTH_B = 16,
   parameter int K            = 9,
   parameter int LUT_WIDTH    = DATA_WIDTH_B + $clog2(K),
   parameter int ACC_WIDTH    = acc_width(DATA_WIDTH_A, DATA_WIDTH_B, K)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic                        slice_valid,
   output logic                        slice_ready,
   input  logic [7:0]                  t,
   input  logic                        sign_in,
   input  logic signed [LUT_WIDTH:0]   lut_in,
`ifdef DA_OBC_OFFSET_EN
   input  logic signed [ACC_WIDTH-1:0] offset_in,
`endif
   output logic                        result_valid,
   input  logic                        result_ready,
   output logic signed [ACC_WIDTH-1:0] result,
   output logic                        busy,
   output logic                        seq_err
);

   localparam int CNT_WIDTH = cnt_width(DATA_WIDTH_A);

   da_acc_state_t               state_reg, state_next;
   logic signed [ACC_WIDTH-1:0] acc_reg;
   logic signed [ACC_WIDTH-1:0] result_reg;
   logic [CNT_WIDTH-1:0]        cnt_reg;
   logic                        seq_err_reg;

   logic signed [ACC_WIDTH-1:0] weighted;
   logic signed [ACC_WIDTH-1:0] init_value;
   logic                        accept;
   logic                        in_seq;
   logic                        last_slice;

`ifdef DA_OBC_OFFSET_EN
   assign init_value = offset_in;
`else
   assign init_value = '0;
`endif

   da_term_weight #(
      .LUT_WIDTH (LUT_WIDTH),
      .ACC_WIDTH (ACC_WIDTH),
      .CNT_WIDTH (CNT_WIDTH)
   ) u_term_weight (
      .lut_in   (lut_in),
      .sign_in  (sign_in),
      .cnt      (cnt_reg),
      .weighted (weighted)
   );

   assign accept     = slice_valid && (state_reg == ACC);
   assign in_seq     = (t == 8'(cnt_reg));
   assign last_slice = (cnt_reg == CNT_WIDTH'(DATA_WIDTH_A - 1));

   // Handshake outputs come straight from the state register.
   always_comb begin
      state_next   = state_reg;
      slice_ready  = 1'b0;
      result_valid = 1'b0;
      busy         = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) state_next = ACC;
         end
         ACC: begin
            slice_ready = 1'b1;
            busy        = 1'b1;
            if (!start && accept && in_seq && last_slice) state_next = DONE;
         end
         DONE: begin
            result_valid = 1'b1;
            busy         = 1'b1;
            if (result_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         acc_reg     <= '0;
         cnt_reg     <= '0;
         result_reg  <= '0;
         seq_err_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         if ((state_reg == IDLE || state_reg == ACC) && start) begin
            // Start in ACC aborts the current word and restarts it.
            acc_reg <= init_value;
            cnt_reg <= '0;
         end else if (accept) begin
            if (!in_seq) begin
               seq_err_reg <= 1'b1;
            end else if (last_slice) begin
               result_reg <= acc_reg - weighted;
               cnt_reg    <= '0;
            end else begin
               acc_reg <= acc_reg + weighted;
               cnt_reg <= cnt_reg + 1'b1;
            end
         end
      end
   end

   assign result  = result_reg;
   assign seq_err = seq_err_reg;

endmodule

// File: tb/tb_da_shift_acc.sv
// Directed self-checking bench for da_shift_acc (default 16/16/9 configuration).
module tb_da_shift_acc;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               start = 1'b0;
   logic               slice_valid = 1'b0;
   logic               slice_ready;
   logic [7:0]         t = 8'd0;
   logic               sign_in = 1'b1;
   logic signed [20:0] lut_in = '0;
   logic signed [36:0] offset_in = -37'sd3;
   logic               result_valid;
   logic               result_ready = 1'b0;
   logic signed [36:0] result;
   logic               busy;
   logic               seq_err;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   da_shift_acc dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .slice_valid  (slice_valid),
      .slice_ready  (slice_ready),
      .t            (t),
      .sign_in      (sign_in),
      .lut_in       (lut_in),
`ifdef DA_OBC_OFFSET_EN
      .offset_in    (offset_in),
`endif
      .result_valid (result_valid),
      .result_ready (result_ready),
      .result       (result),
      .busy         (busy),
      .seq_err      (seq_err)
   );

   task automatic do_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic send_slice(input logic [7:0] ti, input logic s, input logic signed [20:0] l);
      slice_valid = 1'b1;
      t = ti;
      sign_in = s;
      lut_in = l;
      @(posedge clk); #1;
      slice_valid = 1'b0;
   endtask

   // hot_t < 0: every slice carries lv; otherwise only slice hot_t does.
   task automatic send_word(input logic signed [20:0] lv, input int hot_t, input logic sgn);
      do_start();
      for (int i = 0; i < 16; i++)
         send_slice(8'(i), sgn, (hot_t < 0 || hot_t == i) ? lv : 21'sd0);
   endtask

   task automatic release_word();
      result_ready = 1'b1;
      @(posedge clk); #1;
      result_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      checks++;
      if (result_valid !== 1'b0 || slice_ready !== 1'b0 || busy !== 1'b0 ||
          seq_err !== 1'b0 || result !== 37'sd0) begin
         failures++;
         $display("FAIL reset: rv=%b sr=%b busy=%b se=%b result=%0d, required all 0",
                  result_valid, slice_ready, busy, seq_err, result);
      end
   endtask

   task automatic test_constant();
      do_start();
      checks++;
      if (slice_ready !== 1'b1 || busy !== 1'b1) begin
         failures++;
         $display("FAIL acc_state: slice_ready=%b busy=%b, required 1 1", slice_ready, busy);
      end
      for (int i = 0; i < 16; i++) send_slice(8'(i), 1'b1, 21'sd5);
      checks++;
      if (result_valid !== 1'b1 || result !== -37'sd5) begin
         failures++;
         $display("FAIL constant: rv=%b result=%0d, required rv=1 result=-5", result_valid, result);
      end
      checks++;
      if (slice_ready !== 1'b0) begin
         failures++;
         $display("FAIL done_slice_ready: got %b, required 0", slice_ready);
      end
      $display("word constant result=%0d", result);
      release_word();
   endtask

   task automatic test_single_slice();
      send_word(21'sd7, 0, 1'b1);
      checks++;
      if (result_valid !== 1'b1 || result !== 37'sd7) begin
         failures++;
         $display("FAIL single_t0: rv=%b result=%0d, required rv=1 result=7", result_valid, result);
      end
      $display("word single_t0 result=%0d", result);
      release_word();

      send_word(21'sd1, 15, 1'b1);
      checks++;
      if (result_valid !== 1'b1 || result !== -37'sd32768) begin
         failures++;
         $display("FAIL single_t15: rv=%b result=%0d, required rv=1 result=-32768", result_valid, result);
      end
      $display("word single_t15 result=%0d", result);
      release_word();

      send_word(21'sd2, 3, 1'b0);
      checks++;
      if (result_valid !== 1'b1 || result !== -37'sd16) begin
         failures++;
         $display("FAIL single_t3_neg: rv=%b result=%0d, required rv=1 result=-16", result_valid, result);
      end
      $display("word single_t3_neg result=%0d", result);
      release_word();
   endtask

   task automatic test_backpressure();
      send_word(21'sd7, 0, 1'b1);
      slice_valid = 1'b1;
      t = 8'd0;
      lut_in = 21'sd99;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         checks++;
         if (result_valid !== 1'b1 || result !== 37'sd7 || slice_ready !== 1'b0) begin
            failures++;
            $display("FAIL backpressure_c%0d: rv=%b result=%0d sr=%b, required rv=1 result=7 sr=0",
                     c, result_valid, result, slice_ready);
         end
      end
      slice_valid = 1'b0;
      release_word();
      checks++;
      if (busy !== 1'b0 || result_valid !== 1'b0) begin
         failures++;
         $display("FAIL backpressure_release: busy=%b rv=%b, required 0 0", busy, result_valid);
      end
      $display("word backpressure result=%0d", result);
   endtask

   task automatic test_seq_err();
      do_start();
      send_slice(8'd0, 1'b1, 21'sd5);
      send_slice(8'd2, 1'b1, 21'sd100);
      checks++;
      if (seq_err !== 1'b1) begin
         failures++;
         $display("FAIL seq_err_set: got %b, required 1", seq_err);
      end
      for (int i = 1; i < 16; i++) send_slice(8'(i), 1'b1, 21'sd5);
      checks++;
      if (result_valid !== 1'b1 || result !== -37'sd5 || seq_err !== 1'b1) begin
         failures++;
         $display("FAIL seq_err_word: rv=%b result=%0d se=%b, required rv=1 result=-5 se=1",
                  result_valid, result, seq_err);
      end
      $display("word seq_err result=%0d", result);
      release_word();
   endtask

   task automatic test_reset_midword();
      do_start();
      for (int i = 0; i < 8; i++) send_slice(8'(i), 1'b1, 21'sd5);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++;
      if (result_valid !== 1'b0 || slice_ready !== 1'b0 || busy !== 1'b0 ||
          seq_err !== 1'b0 || result !== 37'sd0) begin
         failures++;
         $display("FAIL reset_midword: rv=%b sr=%b busy=%b se=%b result=%0d, required all 0",
                  result_valid, slice_ready, busy, seq_err, result);
      end
      send_word(21'sd7, 0, 1'b1);
      checks++;
      if (result_valid !== 1'b1 || result !== 37'sd7) begin
         failures++;
         $display("FAIL after_reset_word: rv=%b result=%0d, required rv=1 result=7", result_valid, result);
      end
      $display("word after_reset result=%0d", result);
      release_word();
   endtask

   task automatic test_start_abort();
      do_start();
      for (int i = 0; i < 5; i++) send_slice(8'(i), 1'b1, 21'sd9);
      send_word(21'sd3, 1, 1'b1);
      checks++;
      if (result_valid !== 1'b1 || result !== 37'sd6) begin
         failures++;
         $display("FAIL start_abort: rv=%b result=%0d, required rv=1 result=6", result_valid, result);
      end
      do_start();
      checks++;
      if (busy !== 1'b1 || result_valid !== 1'b1 || result !== 37'sd6) begin
         failures++;
         $display("FAIL start_in_done: busy=%b rv=%b result=%0d, required 1 1 6", busy, result_valid, result);
      end
      $display("word start_abort result=%0d", result);
      release_word();
   endtask

   task automatic test_offset();
      logic signed [36:0] expected;
`ifdef DA_OBC_OFFSET_EN
      expected = -37'sd3;
`else
      expected = 37'sd0;
`endif
      offset_in = -37'sd3;
      send_word(21'sd0, -1, 1'b1);
      checks++;
      if (result_valid !== 1'b1 || result !== expected) begin
         failures++;
         $display("FAIL offset: rv=%b result=%0d, required rv=1 result=%0d", result_valid, result, expected);
      end
      $display("word offset result=%0d", result);
      release_word();
   endtask

   initial begin
      test_reset();
      test_constant();
      test_single_slice();
      test_backpressure();
      test_seq_err();
      test_reset_midword();
      test_start_abort();
      test_offset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
